// File: rtl/load_dispatcher_pkg.sv
// load_dispatcher_pkg: shared queue count, counter width and settle FSM encoding
package load_dispatcher_pkg;
  localparam int NQ = 4;
  localparam int COUNT_W = 3;
  localparam int MAX_COUNT = 2**COUNT_W - 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;
endpackage

// File: rtl/load_dispatcher_sat.sv
// sat_updown_counter: occupancy counter that never wraps in either direction
module sat_updown_counter
  import load_dispatcher_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_at_max,
  output logic               o_underflow,
  output logic               o_change
);
  logic [COUNT_W-1:0] r_count;
  logic w_up, w_dn;
  assign o_count = r_count;
  assign o_at_max = r_count == COUNT_W'(MAX_COUNT);
  assign o_underflow = i_dec && r_count == '0;
  // a simultaneous arrival and departure cancel out
  assign w_up = i_inc && !i_dec && !o_at_max;
  assign w_dn = i_dec && !i_inc && r_count != '0;
  assign o_change = w_up || w_dn;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else r_count <= w_up ? r_count + COUNT_W'(1) : w_dn ? r_count - COUNT_W'(1) : r_count;
endmodule

// File: rtl/load_dispatcher.sv
// load_dispatcher: feeds queue occupancies to get_mini and dispatches jobs to its chosen queue
module load_dispatcher
  import load_dispatcher_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [3:0]         mini,
  input  logic [3:0]         done_valid,
  output logic [COUNT_W-1:0] nums1,
  output logic [COUNT_W-1:0] nums2,
  output logic [COUNT_W-1:0] nums3,
  output logic [COUNT_W-1:0] nums4,
  output logic               disp_valid,
  output logic [1:0]         disp_idx,
  output logic               err_underflow,
  output logic               full
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  logic [0:0] r_state;
  logic [SW-1:0] r_settle_cnt;
  logic r_disp_valid, r_err;
  logic [1:0] r_disp_idx;
  logic [NQ-1:0] w_inc, w_at_max, w_uf, w_chg;
  logic [COUNT_W-1:0] w_count [NQ];
  logic w_accept, w_reload;
  for (genvar i = 0; i < NQ; i++) begin : g_q
    assign w_inc[i] = w_accept && mini[1:0] == 2'(i);
    sat_updown_counter u_cnt (
      .clk(clk), .rst_n(rst_n), .i_inc(w_inc[i]), .i_dec(done_valid[i]),
      .o_count(w_count[i]), .o_at_max(w_at_max[i]), .o_underflow(w_uf[i]), .o_change(w_chg[i])
    );
  end
  // readiness uses pre-edge counts, so a full queue never accepts even while retiring
  assign job_ready = r_state == IDLE && mini[3:2] == 2'b00 && !w_at_max[mini[1:0]];
  assign w_accept = job_valid && job_ready;
  assign w_reload = w_accept || |w_chg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= SETTLE;
      r_settle_cnt <= SW'(SETTLE_CYCLES);
      r_disp_valid <= 1'b0;
      r_disp_idx <= 2'd0;
      r_err <= 1'b0;
    end else begin
      r_disp_valid <= w_accept;
      r_disp_idx <= w_accept ? mini[1:0] : r_disp_idx;
      r_err <= |w_uf;
      if (w_reload) begin
        r_state <= SETTLE;
        r_settle_cnt <= SW'(SETTLE_CYCLES);
      end else if (r_state == SETTLE) begin
        r_settle_cnt <= r_settle_cnt - SW'(1);
        r_state <= r_settle_cnt <= SW'(1) ? IDLE : SETTLE;
      end
    end
  assign nums1 = w_count[0];
  assign nums2 = w_count[1];
  assign nums3 = w_count[2];
  assign nums4 = w_count[3];
  assign disp_valid = r_disp_valid;
  assign disp_idx = r_disp_idx;
  assign err_underflow = r_err;
  assign full = &w_at_max;
endmodule
